// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - raster stream to 2x2 stride-2 window assembler for maxpool (optional ReLU: POOL_RELU_EN)
module pool_window_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_in,
    output logic              win_valid,
    output logic [DATA_W-1:0] win_tl,
    output logic [DATA_W-1:0] win_tr,
    output logic [DATA_W-1:0] win_bl,
    output logic [DATA_W-1:0] win_br,
    output logic              frame_done
);

    localparam int COL_W = ($clog2(IMG_W) < 1) ? 1 : $clog2(IMG_W);
    localparam int ROW_W = ($clog2(IMG_H) < 1) ? 1 : $clog2(IMG_H);

    // Last raster positions, and the bottom-right corner of the last complete window
    // (odd trailing column/row never completes a window).
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'((IMG_W / 2) * 2 - 1);
    localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'((IMG_H / 2) * 2 - 1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  eff_col;
    logic [ROW_W-1:0]  eff_row;
    logic [COL_W-1:0]  col_left;
    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] left_reg;
    logic [DATA_W-1:0] row_buf [IMG_W];

    // Position of the current pixel (sof forces 0,0) and the sample after optional ReLU.
    always_comb begin
        eff_col  = pix_sof ? '0 : col;
        eff_row  = pix_sof ? '0 : row;
        col_left = eff_col - 1'b1;
`ifdef POOL_RELU_EN
        pix = pix_in[DATA_W-1] ? '0 : pix_in;
`else
        pix = pix_in;
`endif
    end

    // Raster counters: advance per accepted pixel, wrapping at row and frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (eff_col == COL_LAST) begin
                col <= '0;
                row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end
    end

    // Even rows fill the one-row buffer; never cleared since every entry is written before use.
    always_ff @(posedge clk) begin
        if (!rst && pix_valid && !eff_row[0]) begin
            row_buf[eff_col] <= pix;
        end
    end

    // Odd rows: hold the left pixel, then register the full window on the odd column.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_tl     <= '0;
            win_tr     <= '0;
            win_bl     <= '0;
            win_br     <= '0;
            left_reg   <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid && eff_row[0]) begin
                if (!eff_col[0]) begin
                    left_reg <= pix;
                end else begin
                    win_tl     <= row_buf[col_left];
                    win_tr     <= row_buf[eff_col];
                    win_bl     <= left_reg;
                    win_br     <= pix;
                    win_valid  <= 1'b1;
                    frame_done <= (eff_col == WIN_COL_LAST) && (eff_row == WIN_ROW_LAST);
                end
            end
        end
    end

endmodule
